sixteen_bit_divider: RTL and testbench
======================================

# sixteen_bit_divider

Iterative 16-bit restoring divider, the inverse companion of the combinational 16-bit multiplier in the execute stage. It accepts a dividend/divisor pair on a start pulse and produces quotient and remainder one bit per cycle over 16 cycles, then raises a one-cycle done pulse. It serves the M-extension divide/remainder path and can be shared between DIV and REM requests.

## Interface
- WIDTH, 16: operand and result width. Only 16 is verified.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- operator_1  in  16  dividend, latched on the accepting edge
- operator_2  in  16  divisor, latched on the accepting edge
- is_signed  in  1  two's-complement mode; present only with DIVIDER_SIGNED_EN
- quotient  out  16  registered result
- remainder  out  16  registered result
- busy  out  1  high while state is CALC
- done  out  1  one-cycle pulse; results valid
- div_by_zero  out  1  registered; qualifies the current result

## Operation
- States:
  - IDLE: start=1 latches the operands.
    - Divisor ≠ 0: go to CALC with count=0.
    - Divisor = 0: go directly to DONE.
  - CALC: one restoring step per edge.
    - Shift {rem, dvd} left by 1.
    - Trial-subtract the divisor from the upper half.
    - Keep the difference and set the quotient bit if there is no borrow.
    - count increments each step; the step with count=15 registers the results and goes to DONE.
  - DONE: done=1 for one cycle, then return to IDLE unconditionally.
- start is ignored in CALC and DONE; there is no queueing.
- quotient, remainder and div_by_zero hold their values until the next accepted start.
- Divide by zero (RISC-V semantics): quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
- Internal remainder register is 17 bits wide (borrow bit); outputs are truncated to 16 bits.
- Reset mid-operation: state=IDLE, count=0, all outputs 0, no done pulse. A new start is accepted on the first edge with rst_n=1.

## Timing
- Reset value of every output is 0: quotient, remainder, busy, done, div_by_zero.
- Let E0 be the edge that accepts start.
  - Normal divide: busy is high after E0 through E16. Results register at E16; done is high between E16 and E17; busy is low in that cycle. Latency is 16 cycles.
  - Divide by zero: done is high between E0 and E1. Latency is 1 cycle; busy never rises.
- Minimum start-to-start spacing is 18 edges, or 2 edges for a zero divisor.
- A start held high continuously is re-accepted in the first IDLE cycle after DONE.

## Configuration
- DIVIDER_SIGNED_EN, when defined:
  - The is_signed port exists.
  - With is_signed=1, absolute values are taken combinationally at E0 and signs are fixed up at E16, adding no cycles.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case 16'h8000 / 16'hFFFF gives quotient=16'h8000, remainder=0, div_by_zero=0.
  - Zero divisor gives quotient=16'hFFFF, remainder=dividend, regardless of sign.
- When undefined: the port is absent; the block is unsigned only, and the sign-fixup logic is not elaborated.

## Structure
- Package div_pkg holds:
  - WIDTH
  - the iteration count constant (WIDTH)
  - the state enum: IDLE, CALC, DONE
  - the divide-by-zero constant (all-ones quotient)
- Sub-module sixteen_bit_div_step is one combinational restoring step: inputs partial remainder, dividend bit and divisor; outputs next remainder and quotient bit. The top module instantiates it once per cycle (not unrolled).

## Test plan
- 1000 / 7 → quotient=142, remainder=6; done exactly 16 cycles after the accepting edge; busy high for those 16 cycles only.
- 16'hFFFF / 1 → quotient=16'hFFFF, remainder=0. 5 / 9 → quotient=0, remainder=5.
- 1234 / 0 → quotient=16'hFFFF, remainder=1234, div_by_zero=1, done on the cycle after acceptance; a following 10 / 3 → 3, 1, with div_by_zero back to 0.
- start pulsed during CALC and DONE → ignored, result of the first request unchanged; start held high → next acceptance 18 edges after the first.
- rst_n low for one edge at the 8th CALC cycle → all outputs 0, no done; restart 100 / 10 → 10, 0 on schedule.
- With DIVIDER_SIGNED_EN, is_signed=1:
  - −7 / 2 → 16'hFFFD, 16'hFFFF
  - 7 / −2 → 16'hFFFD, 1
  - 16'h8000 / 16'hFFFF → 16'h8000, 0
  - is_signed=0 with 16'hFFF9 / 2 → 16'h7FFC, 1

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the iterative restoring divider.
package div_pkg;

    localparam int WIDTH = 16;
    localparam int ITERS = WIDTH;
    localparam int CNT_W = $clog2(ITERS);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERS - 1);
    localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

endpackage

// File: rtl/sixteen_bit_div_step.sv
// One combinational restoring step: shift in a dividend bit, trial-subtract, keep or restore.
// Zero latency; no flow control.
module sixteen_bit_div_step
    import div_pkg::*;
(
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // The partial remainder is always below the divisor, so the shifted value fits in
    // WIDTH+1 bits and the extra top bit of diff is a clean borrow flag.
    assign shifted = {rem_in, dvd_bit};
    assign diff    = shifted - {2'b00, divisor};
    assign borrow  = diff[WIDTH+1];

    assign rem_out = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
    assign q_bit   = ~borrow;

endmodule

// File: rtl/sixteen_bit_divider.sv
// Iterative 16-bit restoring divider (quotient + remainder), optional signed mode via DIVIDER_SIGNED_EN.
// Latency 16 cycles from accepting edge to done, 1 cycle for a zero divisor; start ignored while not IDLE.
module sixteen_bit_divider
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operator_1,
    input  logic [WIDTH-1:0] operator_2,
`ifdef DIVIDER_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem_acc;
    logic [WIDTH-1:0] dvd_acc;
    logic [WIDTH-1:0] dsr;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    sixteen_bit_div_step u_step (
        .rem_in  (rem_acc),
        .dvd_bit (dvd_acc[WIDTH-1]),
        .divisor (dsr),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign q_raw = {dvd_acc[WIDTH-2:0], q_bit};
    assign r_raw = rem_next[WIDTH-1:0];

`ifdef DIVIDER_SIGNED_EN
    logic op1_neg;
    logic op2_neg;
    logic neg_q;
    logic neg_r;

    assign op1_neg = is_signed & operator_1[WIDTH-1];
    assign op2_neg = is_signed & operator_2[WIDTH-1];
    assign op_a    = op1_neg ? negate(operator_1) : operator_1;
    assign op_b    = op2_neg ? negate(operator_2) : operator_2;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign q_final = neg_q ? negate(q_raw) : q_raw;
    assign r_final = neg_r ? negate(r_raw) : r_raw;
`else
    assign op_a    = operator_1;
    assign op_b    = operator_2;
    assign q_final = q_raw;
    assign r_final = r_raw;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem_acc     <= '0;
            dvd_acc     <= '0;
            dsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (operator_2 == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= DIV_ZERO_QUOTIENT;
                            remainder   <= operator_1;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= CALC;
                            busy        <= 1'b1;
                            count       <= '0;
                            rem_acc     <= '0;
                            dvd_acc     <= op_a;
                            dsr         <= op_b;
                            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                            neg_q       <= op1_neg ^ op2_neg;
                            neg_r       <= op1_neg;
`endif
                        end
                    end
                end
                CALC: begin
                    rem_acc <= rem_next;
                    dvd_acc <= q_raw;
                    count   <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_final;
                        remainder <= r_final;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sixteen_bit_divider.sv
// Directed self-checking bench for sixteen_bit_divider.
module tb_sixteen_bit_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] operator_1;
    logic [15:0] operator_2;
`ifdef DIVIDER_SIGNED_EN
    logic        is_signed;
`endif
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int total;
    int bad;

    sixteen_bit_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .operator_1  (operator_1),
        .operator_2  (operator_2),
`ifdef DIVIDER_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse; returns one time unit after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        operator_1 = a;
        operator_2 = b;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Edges from the current sample point until done is seen (-1 on timeout); counts busy samples.
    task automatic wait_done(output int edges, output int busy_cnt, output int busy_at_done);
        edges        = -1;
        busy_cnt     = 0;
        busy_at_done = 0;
        for (int n = 0; n < 40; n++) begin
            if (done === 1'b1) begin
                edges        = n;
                busy_at_done = int'(busy);
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        operator_1 = 16'h0;
        operator_2 = 16'h0;
        tick();
        tick();
        total++; if (quotient !== 16'h0)  begin bad++; $display("FAIL reset_quotient got=%h want=0000", quotient); end
        total++; if (remainder !== 16'h0) begin bad++; $display("FAIL reset_remainder got=%h want=0000", remainder); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int e, bc, bd;
        issue(16'd1000, 16'd7);
        wait_done(e, bc, bd);
        total++; if (e != 16)  begin bad++; $display("FAIL basic_latency got=%0d want=16", e); end
        total++; if (bc != 16) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=16", bc); end
        total++; if (bd != 0)  begin bad++; $display("FAIL basic_busy_at_done got=%0d want=0", bd); end
        total++; if (quotient !== 16'd142) begin bad++; $display("FAIL basic_quotient got=%0d want=142", quotient); end
        total++; if (remainder !== 16'd6)  begin bad++; $display("FAIL basic_remainder got=%0d want=6", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b want=0", div_by_zero); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_one_cycle got=%b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
        total++; if (quotient !== 16'd142) begin bad++; $display("FAIL basic_hold got=%0d want=142", quotient); end
    endtask

    task automatic test_patterns();
        logic [15:0] va [5] = '{16'hFFFF, 16'd5, 16'hFFFF, 16'd0, 16'd200};
        logic [15:0] vb [5] = '{16'd1,    16'd9, 16'hFFFF, 16'd5, 16'd9};
        logic [15:0] vq [5] = '{16'hFFFF, 16'd0, 16'd1,    16'd0, 16'd22};
        logic [15:0] vr [5] = '{16'd0,    16'd5, 16'd0,    16'd0, 16'd2};
        int e, bc, bd;
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i]);
            wait_done(e, bc, bd);
            total++; if (e != 16) begin bad++; $display("FAIL pat%0d_latency got=%0d want=16", i, e); end
            total++; if (quotient !== vq[i]) begin bad++; $display("FAIL pat%0d_quotient got=%h want=%h", i, quotient, vq[i]); end
            total++; if (remainder !== vr[i]) begin bad++; $display("FAIL pat%0d_remainder got=%h want=%h", i, remainder, vr[i]); end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int e, bc, bd;
        issue(16'd1234, 16'd0);
        wait_done(e, bc, bd);
        total++; if (e != 0) begin bad++; $display("FAIL dz_latency got=%0d want=0", e); end
        total++; if (bd != 0) begin bad++; $display("FAIL dz_busy got=%0d want=0", bd); end
        total++; if (quotient !== 16'hFFFF) begin bad++; $display("FAIL dz_quotient got=%h want=ffff", quotient); end
        total++; if (remainder !== 16'd1234) begin bad++; $display("FAIL dz_remainder got=%0d want=1234", remainder); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_by_zero); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL dz_done_one_cycle got=%b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_busy_after got=%b want=0", busy); end
        issue(16'd10, 16'd3);
        wait_done(e, bc, bd);
        total++; if (e != 16) begin bad++; $display("FAIL dz_next_latency got=%0d want=16", e); end
        total++; if (quotient !== 16'd3) begin bad++; $display("FAIL dz_next_quotient got=%0d want=3", quotient); end
        total++; if (remainder !== 16'd1) begin bad++; $display("FAIL dz_next_remainder got=%0d want=1", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_next_flag got=%b want=0", div_by_zero); end
        tick();
    endtask

    task automatic test_ignore_start();
        int e, bc, bd;
        issue(16'd200, 16'd9);
        for (int i = 0; i < 4; i++) tick();
        operator_1 = 16'd50;
        operator_2 = 16'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(e, bc, bd);
        total++; if (e != 11) begin bad++; $display("FAIL ign_latency got=%0d want=11", e); end
        total++; if (quotient !== 16'd22) begin bad++; $display("FAIL ign_calc_quotient got=%0d want=22", quotient); end
        total++; if (remainder !== 16'd2) begin bad++; $display("FAIL ign_calc_remainder got=%0d want=2", remainder); end
        // A pulse sampled during the DONE cycle must not start a new divide.
        operator_1 = 16'd60;
        operator_2 = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_done_busy got=%b want=0", busy); end
        total++; if (quotient !== 16'd22) begin bad++; $display("FAIL ign_done_quotient got=%0d want=22", quotient); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n, second, seen_done, first_done, e, bc, bd;
        operator_1 = 16'd100;
        operator_2 = 16'd7;
        start = 1'b1;
        tick();
        second = -1;
        seen_done = 0;
        for (n = 0; n < 40; n++) begin
            if (done === 1'b1) seen_done = 1;
            if (seen_done != 0 && busy === 1'b1) begin
                second = n;
                break;
            end
            tick();
        end
        start = 1'b0;
        total++; if (second != 18) begin bad++; $display("FAIL b2b_spacing got=%0d want=18", second); end
        wait_done(e, bc, bd);
        total++; if (quotient !== 16'd14 || remainder !== 16'd2) begin bad++; $display("FAIL b2b_result got=%0d/%0d want=14/2", quotient, remainder); end
        tick();
        // Held start with a zero divisor re-accepts every 2 edges.
        operator_1 = 16'd9;
        operator_2 = 16'd0;
        start = 1'b1;
        tick();
        first_done = int'(done);
        second = -1;
        for (n = 1; n < 10; n++) begin
            tick();
            if (done === 1'b1) begin
                second = n;
                break;
            end
        end
        start = 1'b0;
        total++; if (first_done != 1) begin bad++; $display("FAIL b2b_dz_first got=%0d want=1", first_done); end
        total++; if (second != 2) begin bad++; $display("FAIL b2b_dz_spacing got=%0d want=2", second); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int e, bc, bd;
        issue(16'd1000, 16'd7);
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        total++; if (quotient !== 16'h0 || remainder !== 16'h0) begin bad++; $display("FAIL rmid_results got=%h/%h want=0000/0000", quotient, remainder); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL rmid_flags got=%b%b%b want=000", busy, done, div_by_zero); end
        rst_n = 1'b1;
        issue(16'd100, 16'd10);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_restart_busy got=%b want=1", busy); end
        wait_done(e, bc, bd);
        total++; if (e != 16) begin bad++; $display("FAIL rmid_latency got=%0d want=16", e); end
        total++; if (quotient !== 16'd10 || remainder !== 16'd0) begin bad++; $display("FAIL rmid_result got=%0d/%0d want=10/0", quotient, remainder); end
        tick();
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        logic [15:0] va [4] = '{16'hFFF9, 16'd7,    16'h8000, 16'hFFF9};
        logic [15:0] vb [4] = '{16'd2,    16'hFFFE, 16'hFFFF, 16'd2};
        logic        vs [4] = '{1'b1,     1'b1,     1'b1,     1'b0};
        logic [15:0] vq [4] = '{16'hFFFD, 16'hFFFD, 16'h8000, 16'h7FFC};
        logic [15:0] vr [4] = '{16'hFFFF, 16'd1,    16'd0,    16'd1};
        int e, bc, bd;
        for (int i = 0; i < 4; i++) begin
            is_signed = vs[i];
            issue(va[i], vb[i]);
            wait_done(e, bc, bd);
            total++; if (e != 16) begin bad++; $display("FAIL sgn%0d_latency got=%0d want=16", i, e); end
            total++; if (quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0) begin
                bad++; $display("FAIL sgn%0d_result got=%h/%h/%b want=%h/%h/0", i, quotient, remainder, div_by_zero, vq[i], vr[i]);
            end
            tick();
        end
        is_signed = 1'b1;
        issue(16'hFFF9, 16'd0);
        wait_done(e, bc, bd);
        total++; if (quotient !== 16'hFFFF || remainder !== 16'hFFF9 || div_by_zero !== 1'b1) begin
            bad++; $display("FAIL sgn_dz got=%h/%h/%b want=ffff/fff9/1", quotient, remainder, div_by_zero);
        end
        is_signed = 1'b0;
        tick();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
`ifdef DIVIDER_SIGNED_EN
        is_signed = 1'b0;
`endif
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
